ritc_train_aligner: RTL and testbench



---
 rtl/ritc_train_aligner_pkg.sv | 28 ++
 rtl/ritc_train_aligner_if.sv | 39 +++
 rtl/ritc_train_aligner_lane_mux.sv | 23 ++
 rtl/ritc_train_aligner.sv | 195 +++++++++++++++++++
 tb/tb_ritc_train_aligner.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ritc_train_aligner_pkg.sv
// ritc_align_pkg: shared constants and FSM encoding for the RITC training
// aligner. Lane geometry, counter width, the default training nibble and
// the controller state enum live here.
package ritc_align_pkg;

    localparam int NUM_LANES        = 12;
    localparam int SAMPLES_PER_LANE = 4;
    localparam int DAT_W            = NUM_LANES * SAMPLES_PER_LANE;
    localparam int LANE_IDX_W       = 4;
    // Settle, wait, match and slip counters. 8 bits covers every legal
    // parameter value (1..255), so these counters never wrap.
    localparam int CNT_W            = 8;
    localparam int ERR_W            = 16;

    // All four rotations of this nibble are distinct.
    localparam logic [SAMPLES_PER_LANE-1:0] TRAIN_PATTERN_DEF = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } align_state_t;

endpackage

// File: rtl/ritc_train_aligner_if.sv
// ritc_train_aligner_if: control/data bundle between one RITC channel's
// datapath and its training aligner.
//   start_i        begin alignment (one-cycle pulse)
//   dat_i          48-bit word, lane l = dat_i[4l+3:4l], bit 4l earliest
//   bitslip_o      one-hot, one-cycle bitslip pulse per lane
//   train_o        request the RITC training pattern
//   busy_o         alignment in progress
//   done_o         one-cycle completion pulse
//   lane_locked_o  per-lane aligned status
//   lane_fail_o    per-lane failed status
//   err_count_o    post-alignment slip monitor count
//                  (RITC_TRAIN_ALIGNER_ERRCNT_EN builds only; else 0)
// Modports: slave = aligner, master = datapath / driver side.
interface ritc_train_aligner_if;
    import ritc_align_pkg::*;

    logic                 start_i;
    logic [DAT_W-1:0]     dat_i;
    logic [NUM_LANES-1:0] bitslip_o;
    logic                 train_o;
    logic                 busy_o;
    logic                 done_o;
    logic [NUM_LANES-1:0] lane_locked_o;
    logic [NUM_LANES-1:0] lane_fail_o;
    logic [ERR_W-1:0]     err_count_o;

    modport slave (
        input  start_i, dat_i,
        output bitslip_o, train_o, busy_o, done_o,
               lane_locked_o, lane_fail_o, err_count_o
    );

    modport master (
        output start_i, dat_i,
        input  bitslip_o, train_o, busy_o, done_o,
               lane_locked_o, lane_fail_o, err_count_o
    );

endinterface

// File: rtl/ritc_train_aligner_lane_mux.sv
// ritc_lane_mux: combinational selection of one lane's nibble out of the
// deserialized channel word.
//   i_dat     full channel word (NUM_LANES x SAMPLES_PER_LANE)
//   i_lane    lane index; out-of-range indices return 0
//   o_nibble  selected lane samples, bit 0 earliest
module ritc_lane_mux
    import ritc_align_pkg::*;
(
    input  logic [DAT_W-1:0]            i_dat,
    input  logic [LANE_IDX_W-1:0]       i_lane,
    output logic [SAMPLES_PER_LANE-1:0] o_nibble
);

    always_comb begin
        o_nibble = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (i_lane == LANE_IDX_W'(l)) begin
                o_nibble = i_dat[l*SAMPLES_PER_LANE +: SAMPLES_PER_LANE];
            end
        end
    end

endmodule

// File: rtl/ritc_train_aligner.sv
// ritc_train_aligner: per-channel RITC training / bit-alignment controller.
// Requests the training pattern, waits for it to settle, then walks lanes
// 0..11, slipping each lane's ISERDES until the nibble matches
// TRAIN_PATTERN for CHECK_CYCLES consecutive cycles or NUM_PHASES slips
// have been spent.
// Ports:
//   SYSCLK  sole clock
//   rst_i   asynchronous, active-high reset
//   bus     ritc_train_aligner_if.slave (start/data in, bitslip/status out)
// Optional build macro: RITC_TRAIN_ALIGNER_ERRCNT_EN enables the post-
// alignment slip monitor on err_count_o; without it err_count_o is 0.
module ritc_train_aligner
    import ritc_align_pkg::*;
#(
    parameter logic [SAMPLES_PER_LANE-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter int SETTLE_CYCLES = 64,
    parameter int SLIP_WAIT     = 8,
    parameter int CHECK_CYCLES  = 16,
    parameter int NUM_PHASES    = 4
) (
    input  logic                 SYSCLK,
    input  logic                 rst_i,
    ritc_train_aligner_if.slave  bus
);

    localparam logic [CNT_W-1:0]      C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      C_WAIT_LAST   = CNT_W'(SLIP_WAIT - 1);
    localparam logic [CNT_W-1:0]      C_CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      C_PHASES      = CNT_W'(NUM_PHASES);
    localparam logic [LANE_IDX_W-1:0] C_LAST_LANE   = LANE_IDX_W'(NUM_LANES - 1);

    align_state_t                r_state;
    align_state_t                w_state_nxt;
    logic [LANE_IDX_W-1:0]       r_lane;
    logic [CNT_W-1:0]            r_cyc_cnt;
    logic [CNT_W-1:0]            r_match_cnt;
    logic [CNT_W-1:0]            r_slip_cnt;
    logic [NUM_LANES-1:0]        r_locked;
    logic [NUM_LANES-1:0]        r_fail;
    logic [SAMPLES_PER_LANE-1:0] w_nibble;
    logic                        w_match;
    logic                        w_start;

    ritc_lane_mux u_lane_mux (
        .i_dat    (bus.dat_i),
        .i_lane   (r_lane),
        .o_nibble (w_nibble)
    );

    assign w_match = (w_nibble == TRAIN_PATTERN);
    assign w_start = (r_state == ST_IDLE) && bus.start_i;

    // ---------------------------------------------------------------- state
    always_ff @(posedge SYSCLK or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start_i) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cyc_cnt == C_SETTLE_LAST) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (w_match) begin
                    if (r_match_cnt == C_CHECK_LAST) w_state_nxt = ST_NEXT;
                end else if (r_slip_cnt < C_PHASES) begin
                    w_state_nxt = ST_SLIP;
                end else begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_SLIP:   w_state_nxt = ST_WAIT;
            ST_WAIT:   if (r_cyc_cnt == C_WAIT_LAST) w_state_nxt = ST_CHECK;
            ST_NEXT:   w_state_nxt = (r_lane == C_LAST_LANE) ? ST_DONE : ST_CHECK;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Decoded straight from the async-reset state register, so bitslip_o
    // and train_o fall the moment rst_i rises.
    always_comb begin
        bus.bitslip_o = '0;
        bus.train_o   = 1'b0;
        bus.busy_o    = 1'b0;
        bus.done_o    = 1'b0;
        case (r_state)
            ST_SETTLE, ST_CHECK, ST_WAIT, ST_NEXT: begin
                bus.train_o = 1'b1;
                bus.busy_o  = 1'b1;
            end
            ST_SLIP: begin
                bus.bitslip_o = NUM_LANES'(1) << r_lane;
                bus.train_o   = 1'b1;
                bus.busy_o    = 1'b1;
            end
            ST_DONE: bus.done_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.lane_locked_o = r_locked;
    assign bus.lane_fail_o   = r_fail;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge SYSCLK or posedge rst_i) begin
        if (rst_i) begin
            r_lane      <= '0;
            r_cyc_cnt   <= '0;
            r_match_cnt <= '0;
            r_slip_cnt  <= '0;
            r_locked    <= '0;
            r_fail      <= '0;
        end else begin
            // Shared settle/wait timer: runs only while staying in SETTLE
            // or WAIT, so it starts from 0 on every entry.
            if ((r_state == ST_SETTLE || r_state == ST_WAIT) && w_state_nxt == r_state)
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            else
                r_cyc_cnt <= '0;

            // Consecutive-match counter: any mismatch or exit restarts it.
            if (r_state == ST_CHECK && w_match && w_state_nxt == ST_CHECK)
                r_match_cnt <= r_match_cnt + 1'b1;
            else
                r_match_cnt <= '0;

            if (r_state == ST_SLIP)
                r_slip_cnt <= r_slip_cnt + 1'b1;
            else if (r_state == ST_SETTLE || r_state == ST_NEXT)
                r_slip_cnt <= '0;

            if (w_start) begin
                r_lane   <= '0;
                r_locked <= '0;
                r_fail   <= '0;
            end else if (r_state == ST_NEXT && r_lane != C_LAST_LANE) begin
                r_lane <= r_lane + 1'b1;
            end

            // CHECK leaves for NEXT either on a full match run or after
            // the last permitted slip; w_match tells which.
            if (r_state == ST_CHECK && w_state_nxt == ST_NEXT) begin
                if (w_match) r_locked[r_lane] <= 1'b1;
                else         r_fail[r_lane]   <= 1'b1;
            end
        end
    end

`ifdef RITC_TRAIN_ALIGNER_ERRCNT_EN
    // Post-alignment slip monitor: with the pattern static, any change in
    // a locked lane's nibble from one cycle to the next means that lane
    // slipped. Armed by DONE, counts only in IDLE, cleared by start.
    logic [DAT_W-1:0]     r_prev_dat;
    logic                 r_mon_armed;
    logic [ERR_W-1:0]     r_err_cnt;
    logic [NUM_LANES-1:0] w_lane_diff;

    always_comb begin
        w_lane_diff = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_lane_diff[l] = r_locked[l] &&
                (bus.dat_i[l*SAMPLES_PER_LANE +: SAMPLES_PER_LANE] !=
                 r_prev_dat[l*SAMPLES_PER_LANE +: SAMPLES_PER_LANE]);
        end
    end

    always_ff @(posedge SYSCLK or posedge rst_i) begin
        if (rst_i) begin
            r_prev_dat  <= '0;
            r_mon_armed <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_prev_dat <= bus.dat_i;
            if (w_start) begin
                r_mon_armed <= 1'b0;
                r_err_cnt   <= '0;
            end else if (r_state == ST_DONE) begin
                r_mon_armed <= 1'b1;
            end else if (r_state == ST_IDLE && r_mon_armed &&
                         (|w_lane_diff) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.err_count_o = r_err_cnt;
`else
    assign bus.err_count_o = '0;
`endif

endmodule

// File: tb/tb_ritc_train_aligner.sv
// tb_ritc_train_aligner: self-checking bench for ritc_train_aligner.
// A lane model drives each lane either as the training nibble rotated by
// a per-lane offset (each bitslip pulse advances the rotation by one) or
// as random non-pattern data. Expected slip counts, status masks and
// completion latency are computed from the alignment rules with plain
// arithmetic.
module tb_ritc_train_aligner;
    import ritc_align_pkg::*;

    localparam logic [3:0] PAT     = 4'b0011;
    localparam int         SETTLE  = 64;
    localparam int         SWAIT   = 8;
    localparam int         CHECKC  = 16;
    localparam int         PHASES  = 4;
    localparam int         TIMEOUT = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ritc_train_aligner_if bus ();

    ritc_train_aligner #(
        .TRAIN_PATTERN (PAT),
        .SETTLE_CYCLES (SETTLE),
        .SLIP_WAIT     (SWAIT),
        .CHECK_CYCLES  (CHECKC),
        .NUM_PHASES    (PHASES)
    ) dut (
        .SYSCLK (clk),
        .rst_i  (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Lane setup written by the tests; mode 0 = rotated pattern,
    // 1 = random non-pattern, 2 = toggling pattern.
    int mode[NUM_LANES];
    int init_rot[NUM_LANES];
    int epoch = 0;

    // Owned by the lane model process.
    int seen_epoch = -1;
    int rot[NUM_LANES];
    int slips[NUM_LANES];
    int last_slip[NUM_LANES];
    int min_gap[NUM_LANES];
    int mcyc = 0;
    bit multi = 1'b0;
    bit tog = 1'b0;

    function automatic logic [3:0] rotl(input logic [3:0] p, input int r);
        logic [3:0] x;
        x = p;
        for (int i = 0; i < r; i++) x = {x[2:0], x[3]};
        return x;
    endfunction

    // Lane model: reacts to bitslip pulses and drives dat_i, all on the
    // falling edge so the DUT samples stable data.
    initial begin
        logic [DAT_W-1:0] d;
        logic [3:0] nib;
        bus.dat_i = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            tog = ~tog;
            if (seen_epoch != epoch) begin
                seen_epoch = epoch;
                multi = 1'b0;
                for (int l = 0; l < NUM_LANES; l++) begin
                    rot[l] = init_rot[l]; slips[l] = 0;
                    last_slip[l] = -1; min_gap[l] = 1000000;
                end
            end else begin
                if ($countones(bus.bitslip_o) > 1) multi = 1'b1;
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (bus.bitslip_o[l]) begin
                        slips[l]++;
                        if (last_slip[l] >= 0 && mcyc - last_slip[l] < min_gap[l])
                            min_gap[l] = mcyc - last_slip[l];
                        last_slip[l] = mcyc;
                        rot[l] = (rot[l] + 1) % 4;
                    end
                end
            end
            d = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (mode[l] == 1) begin
                    do nib = 4'($urandom_range(0, 15)); while (nib == PAT);
                end else if (mode[l] == 2) begin
                    nib = tog ? PAT : 4'b0110;
                end else begin
                    nib = rotl(PAT, rot[l]);
                end
                d[l*4 +: 4] = nib;
            end
            bus.dat_i = d;
        end
    end

    // ------------------------------------------------------------ reference
    function automatic int model_slips(input int l);
        return (mode[l] == 1) ? PHASES : (4 - init_rot[l]) % 4;
    endfunction

    function automatic int model_cycles();
        int t;
        t = 1 + SETTLE;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (mode[l] == 1) t += PHASES * (SWAIT + 2) + 2;
            else              t += model_slips(l) * (SWAIT + 2) + CHECKC + 1;
        end
        return t;
    endfunction

    function automatic logic [NUM_LANES-1:0] model_locked();
        logic [NUM_LANES-1:0] m;
        for (int l = 0; l < NUM_LANES; l++) m[l] = (mode[l] == 0);
        return m;
    endfunction

    // --------------------------------------------------------------- helpers
    task automatic set_aligned();
        for (int l = 0; l < NUM_LANES; l++) begin mode[l] = 0; init_rot[l] = 0; end
    endtask

    task automatic arm();
        epoch++;
        @(negedge clk);
    endtask

    // Pulses start_i and returns the cycle index at which done_o is seen
    // (start cycle = 0), or ok=0 if the bound expires.
    task automatic run_seq(output int n, output bit ok);
        @(negedge clk); bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
        n = 1; ok = 1'b0;
        while (n < TIMEOUT) begin
            if (bus.done_o) begin ok = 1'b1; break; end
            @(negedge clk); n++;
        end
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; bus.start_i = 1'b0;
        set_aligned();
        repeat (3) @(negedge clk);
        checks++; if (bus.bitslip_o !== '0) begin errors++; $display("FAIL reset_bitslip got %h want 000", bus.bitslip_o); end
        checks++; if (bus.train_o !== 1'b0) begin errors++; $display("FAIL reset_train got %b want 0", bus.train_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        checks++; if (bus.lane_locked_o !== '0) begin errors++; $display("FAIL reset_locked got %h want 000", bus.lane_locked_o); end
        checks++; if (bus.lane_fail_o !== '0) begin errors++; $display("FAIL reset_fail got %h want 000", bus.lane_fail_o); end
        checks++; if (bus.err_count_o !== '0) begin errors++; $display("FAIL reset_errcnt got %h want 0000", bus.err_count_o); end
        rst = 1'b0;
        arm();
    endtask

    task automatic test_all_aligned();
        int n; bit ok; int tot;
        set_aligned(); arm();
        run_seq(n, ok);
        tot = 0;
        for (int l = 0; l < NUM_LANES; l++) tot += slips[l];
        checks++; if (!ok) begin errors++; $display("FAIL aligned_timeout got none want done_o"); end
        checks++; if (n != 269) begin errors++; $display("FAIL aligned_latency got %0d want 269", n); end
        checks++; if (bus.lane_locked_o !== 12'hFFF) begin errors++; $display("FAIL aligned_locked got %h want FFF", bus.lane_locked_o); end
        checks++; if (bus.lane_fail_o !== 12'h000) begin errors++; $display("FAIL aligned_fail got %h want 000", bus.lane_fail_o); end
        checks++; if (tot != 0) begin errors++; $display("FAIL aligned_slips got %0d want 0", tot); end
        @(negedge clk);
        checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.train_o !== 1'b0) begin
            errors++; $display("FAIL aligned_after_done got done=%b busy=%b train=%b want 0 0 0", bus.done_o, bus.busy_o, bus.train_o);
        end
    endtask

    task automatic test_lane3_rotated();
        int n; bit ok;
        set_aligned(); init_rot[3] = 2; arm();
        run_seq(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lane3_timeout got none want done_o"); end
        checks++; if (n != model_cycles()) begin errors++; $display("FAIL lane3_latency got %0d want %0d", n, model_cycles()); end
        checks++; if (slips[3] != 2) begin errors++; $display("FAIL lane3_slips got %0d want 2", slips[3]); end
        checks++; if (min_gap[3] < SWAIT + 1) begin errors++; $display("FAIL lane3_gap got %0d want >=%0d", min_gap[3], SWAIT + 1); end
        checks++; if (bus.lane_locked_o !== 12'hFFF) begin errors++; $display("FAIL lane3_locked got %h want FFF", bus.lane_locked_o); end
        checks++; if (bus.lane_fail_o !== 12'h000) begin errors++; $display("FAIL lane3_fail got %h want 000", bus.lane_fail_o); end
    endtask

    task automatic test_lane7_random();
        int n; bit ok;
        set_aligned(); mode[7] = 1; arm();
        run_seq(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lane7_timeout got none want done_o"); end
        checks++; if (n != model_cycles()) begin errors++; $display("FAIL lane7_latency got %0d want %0d", n, model_cycles()); end
        checks++; if (slips[7] != PHASES) begin errors++; $display("FAIL lane7_slips got %0d want %0d", slips[7], PHASES); end
        checks++; if (bus.lane_fail_o !== 12'h080) begin errors++; $display("FAIL lane7_fail got %h want 080", bus.lane_fail_o); end
        checks++; if (bus.lane_locked_o !== 12'hF7F) begin errors++; $display("FAIL lane7_locked got %h want F7F", bus.lane_locked_o); end
    endtask

    task automatic test_random();
        int n; bit ok;
        for (int it = 0; it < 4; it++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                init_rot[l] = $urandom_range(0, 3);
                mode[l] = ($urandom_range(0, 5) == 0) ? 1 : 0;
            end
            arm();
            run_seq(n, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout got none want done_o", it); end
            checks++; if (n != model_cycles()) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", it, n, model_cycles()); end
            checks++; if (bus.lane_locked_o !== model_locked()) begin errors++; $display("FAIL rnd%0d_locked got %h want %h", it, bus.lane_locked_o, model_locked()); end
            checks++; if (bus.lane_fail_o !== ~model_locked()) begin errors++; $display("FAIL rnd%0d_fail got %h want %h", it, bus.lane_fail_o, ~model_locked()); end
            checks++; if (multi) begin errors++; $display("FAIL rnd%0d_onehot got multi-lane pulse want one-hot", it); end
            for (int l = 0; l < NUM_LANES; l++) begin
                checks++; if (slips[l] != model_slips(l)) begin errors++; $display("FAIL rnd%0d_slips_l%0d got %0d want %0d", it, l, slips[l], model_slips(l)); end
                checks++; if (min_gap[l] < SWAIT + 1) begin errors++; $display("FAIL rnd%0d_gap_l%0d got %0d want >=%0d", it, l, min_gap[l], SWAIT + 1); end
            end
        end
    endtask

    task automatic test_reset_midwait();
        int n; bit ok; bit seen; bit saw_done;
        set_aligned(); init_rot[5] = 1; arm();
        @(negedge clk); bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            if (bus.bitslip_o[5]) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrst_slip5 got none want bitslip_o[5] pulse"); end
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++; if (bus.bitslip_o !== '0 || bus.train_o !== 1'b0) begin
            errors++; $display("FAIL midrst_async got bitslip=%h train=%b want 000 0", bus.bitslip_o, bus.train_o);
        end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy_o); end
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); saw_done |= bus.done_o; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); saw_done |= bus.done_o; end
        checks++; if (saw_done) begin errors++; $display("FAIL midrst_done got pulse want none"); end
        set_aligned(); arm();
        run_seq(n, ok);
        checks++; if (!ok || n != 269) begin errors++; $display("FAIL midrst_rerun got ok=%0d n=%0d want ok=1 n=269", ok, n); end
        checks++; if (bus.lane_locked_o !== 12'hFFF || slips[5] != 0) begin
            errors++; $display("FAIL midrst_rerun_status got locked=%h slips5=%0d want FFF 0", bus.lane_locked_o, slips[5]);
        end
    endtask

    task automatic test_restart_busy();
        int n; bit ok;
        set_aligned(); mode[7] = 1; arm();
        run_seq(n, ok);
        set_aligned(); arm();
        @(negedge clk); bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
        n = 1; ok = 1'b0;
        while (n < TIMEOUT) begin
            if (n == 100) bus.start_i = 1'b1;
            if (n == 101) begin
                bus.start_i = 1'b0;
                checks++; if (bus.lane_locked_o[0] !== 1'b1 || bus.busy_o !== 1'b1) begin
                    errors++; $display("FAIL restart_status got locked0=%b busy=%b want 1 1", bus.lane_locked_o[0], bus.busy_o);
                end
            end
            if (bus.done_o) begin ok = 1'b1; break; end
            @(negedge clk); n++;
        end
        checks++; if (!ok || n != 269) begin errors++; $display("FAIL restart_latency got ok=%0d n=%0d want ok=1 n=269", ok, n); end
        checks++; if (bus.lane_locked_o !== 12'hFFF) begin errors++; $display("FAIL restart_locked got %h want FFF", bus.lane_locked_o); end
    endtask

`ifdef RITC_TRAIN_ALIGNER_ERRCNT_EN
    task automatic test_errcnt();
        int n; bit ok;
        set_aligned(); arm();
        run_seq(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL errcnt_run got none want done_o"); end
        mode[0] = 2; arm();
        repeat (70000) @(negedge clk);
        checks++; if (bus.err_count_o !== 16'hFFFF) begin errors++; $display("FAIL errcnt_sat got %h want FFFF", bus.err_count_o); end
        set_aligned(); arm();
        repeat (3) @(negedge clk);
        checks++; if (bus.err_count_o !== 16'hFFFF) begin errors++; $display("FAIL errcnt_hold got %h want FFFF", bus.err_count_o); end
        run_seq(n, ok);
        checks++; if (bus.err_count_o !== 16'h0000) begin errors++; $display("FAIL errcnt_clear got %h want 0000", bus.err_count_o); end
    endtask
`else
    task automatic test_errcnt();
        set_aligned(); arm();
        repeat (2) @(negedge clk);
        checks++; if (bus.err_count_o !== 16'h0000) begin errors++; $display("FAIL errcnt_off got %h want 0000", bus.err_count_o); end
    endtask
`endif

    initial begin
        bus.start_i = 1'b0;
        test_reset();
        test_all_aligned();
        test_lane3_rotated();
        test_lane7_random();
        test_random();
        test_reset_midwait();
        test_restart_busy();
        test_errcnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
